// File: rtl/qc_ldpc_pkg.sv
// -----------------------------------------------------------------------------
// qc_ldpc_pkg
// Shared definitions for the QC-LDPC row accumulator slice.
//   MAXZ_DEF       : default maximum lifting size (equals the shifter width).
//   ZW_DEF         : width of a lifting-size field for MAXZ_DEF.
//   row_entry_t    : one completed row as held in the output FIFO when the
//                    zero-flag option (ROW_ZERO_FLAG_EN) is built in.
//   shift_latency  : pipeline depth of the circular shifter for a given width.
//   z_mask         : MAXZ_DEF-bit mask keeping bits below the effective Z.
// -----------------------------------------------------------------------------
package qc_ldpc_pkg;

    localparam int unsigned MAXZ_DEF = 81;
    localparam int unsigned ZW_DEF   = $clog2(MAXZ_DEF) + 1;

    typedef struct packed {
        logic                zero;
        logic [MAXZ_DEF-1:0] data;
    } row_entry_t;

    // The barrel shifter resolves one shift-amount bit per stage.
    function automatic int unsigned shift_latency(input int unsigned maxz);
        return $clog2(maxz);
    endfunction

    // Bit k is set iff k < Zeff. A lifting size of zero or one beyond the
    // datapath width selects the full width instead of masking everything.
    function automatic logic [MAXZ_DEF-1:0] z_mask(input logic [ZW_DEF-1:0] z,
                                                   input int unsigned      maxz);
        logic [MAXZ_DEF-1:0] m;
        int unsigned         zeff;
        zeff = 32'(z);
        if (zeff == 0 || zeff > maxz) begin
            zeff = maxz;
        end
        for (int unsigned k = 0; k < MAXZ_DEF; k++) begin
            m[k] = (k < zeff);
        end
        return m;
    endfunction

endpackage

// File: rtl/qc_ldpc_row_fifo.sv
// -----------------------------------------------------------------------------
// qc_ldpc_row_fifo
// Small first-word-fall-through FIFO holding completed row sums.
//   clk_i, rst_i : clock, asynchronous active-high reset (clears pointers)
//   push_i       : write push_data_i this cycle (caller guarantees not full)
//   push_data_i  : entry to store
//   pop_i        : drop the head entry (ignored when empty)
//   valid_o      : head_o holds a valid entry
//   head_o       : oldest entry
//   count_o      : number of stored entries, 0..DEPTH
// DEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module qc_ldpc_row_fifo #(
    parameter int unsigned WIDTH = 81,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic                       valid_o,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign valid_o = (wr_ptr_q != rd_ptr_q);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign do_pop  = pop_i & valid_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset; stale entries are never visible past valid_o.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/qc_ldpc_row_accumulator.sv
// -----------------------------------------------------------------------------
// qc_ldpc_row_accumulator
// Follows the pipelined circular shifter. Issue tags ride a delay line equal to
// the shifter latency so each tap lines up with its rotated sub-block; valid
// sub-blocks are masked to the lifting size and XOR-accumulated per base-matrix
// row. Completed rows go to a small output FIFO. Because the shifter cannot
// stall, upstream issue is throttled by a credit count of rows committed but
// not yet popped.
//
// Ports:
//   CLK, rst      : clock, asynchronous active-high reset
//   issue_valid   : a beat enters the shifter this cycle
//   issue_last    : that beat closes its row
//   issue_ready   : beat accepted on issue_valid & issue_ready
//   z_size        : active lifting size (0 or >MAXZ means full width)
//   shifted_data  : shifter output
//   row_data      : FIFO head row sum (zero while row_valid is low)
//   row_valid     : FIFO head valid
//   row_ready     : downstream takes the head
//   row_zero      : head row sum is all-zero (only with ROW_ZERO_FLAG_EN)
//   err_overflow  : sticky, a row carried more than MAX_COLS beats
//
// Build option: define ROW_ZERO_FLAG_EN to add the row_zero output and the
// matching FIFO bit. MAXZ may not exceed qc_ldpc_pkg::MAXZ_DEF.
// -----------------------------------------------------------------------------
module qc_ldpc_row_accumulator
    import qc_ldpc_pkg::*;
#(
    parameter int unsigned MAXZ      = MAXZ_DEF,
    parameter int unsigned SHIFT_LAT = shift_latency(MAXZ),
    parameter int unsigned MAX_COLS  = 24,
    parameter int unsigned OUT_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic                  issue_last,
    output logic                  issue_ready,
    input  logic [$clog2(MAXZ):0] z_size,
    input  logic [MAXZ-1:0]       shifted_data,
    output logic [MAXZ-1:0]       row_data,
    output logic                  row_valid,
    input  logic                  row_ready,
`ifdef ROW_ZERO_FLAG_EN
    output logic                  row_zero,
`endif
    output logic                  err_overflow
);

    localparam int unsigned CNT_W = $clog2(MAX_COLS + 1);
    localparam int unsigned CRD_W = $clog2(OUT_DEPTH + 1);
`ifdef ROW_ZERO_FLAG_EN
    localparam int unsigned FIFO_W = $bits(row_entry_t);
`else
    localparam int unsigned FIFO_W = MAXZ;
`endif

    logic                 issue_fire;
    logic                 last_fire;
    logic                 row_pop;
    logic [SHIFT_LAT-1:0] tag_valid_q, tag_valid_d;
    logic [SHIFT_LAT-1:0] tag_last_q, tag_last_d;
    logic                 tap_valid;
    logic                 tap_last;
    logic [MAXZ_DEF-1:0]  mask_full;
    logic [MAXZ-1:0]      mask;
    logic [MAXZ-1:0]      masked_data;
    logic [MAXZ-1:0]      acc_q, acc_d;
    logic [MAXZ-1:0]      row_sum;
    logic                 first_beat_q, first_beat_d;
    logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]     beat_base;
    logic                 err_q, err_d;
    logic [CRD_W-1:0]     committed_q, committed_d;
    logic                 push_row;
    logic                 fifo_push;
    logic                 fifo_valid;
    logic [FIFO_W-1:0]    fifo_push_data;
    logic [FIFO_W-1:0]    fifo_head;
    logic [CRD_W-1:0]     fifo_count;

    // ---------------------------------------------------------------- credit
    assign issue_ready = (committed_q < CRD_W'(OUT_DEPTH));
    assign issue_fire  = issue_valid & issue_ready;
    assign last_fire   = issue_fire & issue_last;
    assign row_pop     = fifo_valid & row_ready;

    always_comb begin
        committed_d = committed_q;
        if (last_fire && !row_pop) begin
            committed_d = committed_q + CRD_W'(1);
        end else if (!last_fire && row_pop) begin
            committed_d = committed_q - CRD_W'(1);
        end
    end

    // -------------------------------------------------------------- tag line
    for (genvar gi = 0; gi < SHIFT_LAT; gi++) begin : g_tag
        if (gi == 0) begin : g_head
            assign tag_valid_d[gi] = issue_fire;
            assign tag_last_d[gi]  = issue_last;
        end else begin : g_body
            assign tag_valid_d[gi] = tag_valid_q[gi-1];
            assign tag_last_d[gi]  = tag_last_q[gi-1];
        end
    end

    assign tap_valid = tag_valid_q[SHIFT_LAT-1];
    assign tap_last  = tag_last_q[SHIFT_LAT-1];

    // ---------------------------------------------------------- accumulator
    assign mask_full   = z_mask(ZW_DEF'(z_size), MAXZ);
    assign mask        = mask_full[MAXZ-1:0];
    assign masked_data = shifted_data & mask;

    always_comb begin
        row_sum      = (first_beat_q ? '0 : acc_q) ^ masked_data;
        beat_base    = first_beat_q ? '0 : beat_cnt_q;
        acc_d        = acc_q;
        first_beat_d = first_beat_q;
        beat_cnt_d   = beat_cnt_q;
        err_d        = err_q;
        push_row     = 1'b0;
        if (tap_valid) begin
            // Counter saturates; the over-long row is still summed and emitted.
            if (beat_base == CNT_W'(MAX_COLS)) begin
                err_d      = 1'b1;
                beat_cnt_d = CNT_W'(MAX_COLS);
            end else begin
                beat_cnt_d = beat_base + CNT_W'(1);
            end
            if (tap_last) begin
                push_row     = 1'b1;
                acc_d        = '0;
                first_beat_d = 1'b1;
                beat_cnt_d   = '0;
            end else begin
                acc_d        = row_sum;
                first_beat_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            tag_valid_q  <= '0;
            tag_last_q   <= '0;
            acc_q        <= '0;
            first_beat_q <= 1'b1;
            beat_cnt_q   <= '0;
            err_q        <= 1'b0;
            committed_q  <= '0;
        end else begin
            tag_valid_q  <= tag_valid_d;
            tag_last_q   <= tag_last_d;
            acc_q        <= acc_d;
            first_beat_q <= first_beat_d;
            beat_cnt_q   <= beat_cnt_d;
            err_q        <= err_d;
            committed_q  <= committed_d;
        end
    end

    assign err_overflow = err_q;

    // ------------------------------------------------------------ output FIFO
    // Credits cap rows in flight at OUT_DEPTH, so the full check never fires
    // in normal operation; it only keeps a stray push from corrupting state.
    assign fifo_push = push_row & (fifo_count != CRD_W'(OUT_DEPTH));

`ifdef ROW_ZERO_FLAG_EN
    row_entry_t push_entry;
    row_entry_t head_entry;

    always_comb begin
        push_entry      = '0;
        push_entry.data = row_sum;
        push_entry.zero = ~|row_sum;
    end

    assign fifo_push_data = push_entry;
    assign head_entry     = fifo_head;
    assign row_data       = fifo_valid ? head_entry.data : '0;
    assign row_zero       = fifo_valid & head_entry.zero;
`else
    assign fifo_push_data = row_sum;
    assign row_data       = fifo_valid ? fifo_head : '0;
`endif

    assign row_valid = fifo_valid;

    qc_ldpc_row_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (OUT_DEPTH)
    ) u_row_fifo (
        .clk_i       (CLK),
        .rst_i       (rst),
        .push_i      (fifo_push),
        .push_data_i (fifo_push_data),
        .pop_i       (row_ready),
        .valid_o     (fifo_valid),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

endmodule
